// File: rtl/simon_engine.sv
// simon_engine: Simon game core. Grows a random colour sequence one entry per
// round, plays it back on the lamp outputs using TICK-based on/off timing, then
// checks the player's entries against it with an inter-entry timeout. Reports
// the number of completed rounds, a loss flag and a win flag.
module simon_engine #(
    parameter int N_CH          = 4,
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 50,
    localparam int CW           = $clog2(N_CH),
    localparam int LW           = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          TICK,
    input  logic          START,
    input  logic [CW-1:0] IN,
    input  logic          IN_VALID,
    input  logic [CW-1:0] RAND,
    output logic [CW-1:0] OUT,
    output logic          OUT_ENA,
    output logic          BUSY,
    output logic [LW-1:0] SCORE,
    output logic          GAME_OVER,
    output logic          WIN
);

    // Address width of the sequence memory (at least one bit for depth 1).
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // One shared timer covers every tick-counted wait, so size it for the longest.
    localparam int MAXT = (ON_TICKS > OFF_TICKS)
                        ? ((ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS)
                        : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
    localparam int TW   = $clog2(MAXT + 1);

    localparam logic [TW-1:0] TMAX     = {TW{1'b1}};
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [LW-1:0] ONE_L    = LW'(1);
    localparam logic [LW-1:0] FULL_L   = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, PAUSE
    } state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [TW-1:0] timer;
    logic [CW-1:0] mem [MAX_LEN];

    logic [LW-1:0] idx_nxt;
    logic [CW-1:0] cur_sym;
    logic [CW-1:0] nxt_sym;
    logic          idx_last;

    // Timer increments saturate so a long wait can never wrap back to zero.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == TMAX) ? t : t + TW'(1);
    endfunction

    assign idx_nxt  = idx + ONE_L;
    assign cur_sym  = mem[idx[AW-1:0]];
    assign nxt_sym  = mem[idx_nxt[AW-1:0]];
    assign idx_last = (idx == len - ONE_L);

    // Sequence memory: append the random channel once per round; no reset needed.
    always_ff @(posedge CLK) begin
        if (state == ADD)
            mem[len[AW-1:0]] <= RAND;
    end

    // Game controller with all outputs registered alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            OUT       <= '0;
            OUT_ENA   <= 1'b0;
            BUSY      <= 1'b0;
            SCORE     <= '0;
            GAME_OVER <= 1'b0;
            WIN       <= 1'b0;
            len       <= '0;
            idx       <= '0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        len       <= '0;
                        SCORE     <= '0;
                        GAME_OVER <= 1'b0;
                        WIN       <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    len     <= len + ONE_L;
                    idx     <= '0;
                    timer   <= '0;
                    // In the first round mem[0] is being written this very edge.
                    OUT     <= (len == '0) ? RAND : mem[0];
                    OUT_ENA <= 1'b1;
                    state   <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (TICK) begin
                        if (timer == ON_LAST) begin
                            timer   <= '0;
                            OUT_ENA <= 1'b0;
                            state   <= SHOW_OFF;
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end
                end
                SHOW_OFF: begin
                    if (TICK) begin
                        if (timer == OFF_LAST) begin
                            timer <= '0;
                            if (idx_last) begin
                                idx   <= '0;
                                state <= WAIT_IN;
                            end else begin
                                idx     <= idx_nxt;
                                OUT     <= nxt_sym;
                                OUT_ENA <= 1'b1;
                                state   <= SHOW_ON;
                            end
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end
                end
                WAIT_IN: begin
                    // A press takes priority over a coincident timeout tick.
                    if (IN_VALID) begin
                        if (IN == cur_sym) begin
                            timer <= '0;
                            if (idx_last) begin
                                SCORE <= SCORE + ONE_L;
                                if (len == FULL_L) begin
                                    WIN   <= 1'b1;
                                    BUSY  <= 1'b0;
                                    state <= IDLE;
                                end else begin
                                    state <= PAUSE;
                                end
                            end else begin
                                idx <= idx_nxt;
                            end
                        end else begin
                            GAME_OVER <= 1'b1;
                            BUSY      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (TICK) begin
                        if (timer == TO_LAST) begin
                            GAME_OVER <= 1'b1;
                            BUSY      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end
                end
                PAUSE: begin
                    if (TICK) begin
                        if (timer == OFF_LAST) begin
                            timer <= '0;
                            state <= ADD;
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end
                end
                default: begin
                    BUSY    <= 1'b0;
                    OUT_ENA <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
// tb_simon_engine: directed bench for simon_engine with N_CH=4, MAX_LEN=3,
// ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=5 and TICK tied high, so each played
// lamp takes 3 cycles and a player has 5 cycles per entry.
module tb_simon_engine;

    logic       CLK = 1'b0;
    logic       RST;
    logic       TICK;
    logic       START;
    logic [1:0] IN;
    logic       IN_VALID;
    logic [1:0] RAND;
    logic [1:0] OUT;
    logic       OUT_ENA;
    logic       BUSY;
    logic [1:0] SCORE;
    logic       GAME_OVER;
    logic       WIN;

    int errs   = 0;
    int checks = 0;

    logic [1:0] seq [3];

    simon_engine #(
        .N_CH(4), .MAX_LEN(3), .ON_TICKS(2), .OFF_TICKS(1), .TIMEOUT_TICKS(5)
    ) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .IN(IN),
        .IN_VALID(IN_VALID), .RAND(RAND), .OUT(OUT), .OUT_ENA(OUT_ENA),
        .BUSY(BUSY), .SCORE(SCORE), .GAME_OVER(GAME_OVER), .WIN(WIN)
    );

    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] v);
        IN       = v;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
    endtask

    // From the first SHOW_ON cycle, check every lamp of round r; ends in WAIT_IN.
    task automatic play_show(input int r);
        for (int i = 0; i < r; i++) begin
            chk($sformatf("show_ena_r%0d_%0d", r, i), OUT_ENA, 1);
            chk($sformatf("show_out_r%0d_%0d", r, i), OUT, seq[i]);
            repeat (3) tick();
        end
        chk($sformatf("wait_ena_r%0d", r), OUT_ENA, 0);
    endtask

    // Enter the whole sequence of round r correctly.
    task automatic answer(input int r);
        for (int i = 0; i < r; i++) press(seq[i]);
        chk($sformatf("score_r%0d", r), SCORE, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; TICK = 1'b1; START = 1'b0; IN = '0; IN_VALID = 1'b0; RAND = '0;
        tick(); tick();
        RST = 1'b0;
        chk("rst_ena", OUT_ENA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_score", SCORE, 0);
        chk("rst_go", GAME_OVER, 0);
        chk("rst_win", WIN, 0);

        // Game A: round 1 timing, ignored inputs, timer restart on entries, timeout.
        RAND = 2; START = 1'b1;
        tick();                       // n+1: ADD
        START = 1'b0;
        chk("a_add_busy", BUSY, 1);
        chk("a_add_ena", OUT_ENA, 0);
        tick();                       // n+2
        chk("a_n2_ena", OUT_ENA, 1);
        chk("a_n2_out", OUT, 2);
        tick();                       // n+3
        chk("a_n3_ena", OUT_ENA, 1);
        chk("a_n3_out", OUT, 2);
        tick();                       // n+4
        chk("a_n4_ena", OUT_ENA, 0);
        tick();                       // n+5: WAIT_IN
        IN = 2; IN_VALID = 1'b1;
        tick();                       // m+1: PAUSE
        IN_VALID = 1'b0;
        chk("a_score1", SCORE, 1);
        chk("a_pause_busy", BUSY, 1);
        RAND = 3;
        tick();                       // m+2: ADD
        chk("a_add2_ena", OUT_ENA, 0);
        tick();                       // m+3: first lamp, inject ignored inputs
        chk("a_r2l0_ena", OUT_ENA, 1);
        chk("a_r2l0_out", OUT, 2);
        IN = 0; IN_VALID = 1'b1; START = 1'b1;
        tick();                       // m+4
        IN_VALID = 1'b0; START = 1'b0;
        chk("a_r2l0_ena_b", OUT_ENA, 1);
        tick();                       // m+5: SHOW_OFF
        chk("a_r2off_ena", OUT_ENA, 0);
        chk("a_r2off_out", OUT, 2);
        IN = 1; IN_VALID = 1'b1;
        tick();                       // m+6: second lamp
        IN_VALID = 1'b0;
        chk("a_r2l1_ena", OUT_ENA, 1);
        chk("a_r2l1_out", OUT, 3);
        tick(); tick(); tick();       // w = m+9: WAIT_IN
        chk("a_w_ena", OUT_ENA, 0);
        chk("a_w_busy", BUSY, 1);
        repeat (3) tick();            // w+3
        press(2);                     // w+4
        chk("a_e1_busy", BUSY, 1);
        chk("a_e1_go", GAME_OVER, 0);
        repeat (3) tick();            // w+7: fourth cycle after first entry
        press(3);                     // w+8: PAUSE
        chk("a_score2", SCORE, 2);
        chk("a_score2_go", GAME_OVER, 0);
        chk("a_score2_busy", BUSY, 1);
        RAND = 0;
        repeat (15) tick();           // w+23: last cycle before timeout
        chk("a_pre_to_go", GAME_OVER, 0);
        chk("a_pre_to_busy", BUSY, 1);
        tick();                       // w+24
        chk("a_to_go", GAME_OVER, 1);
        chk("a_to_busy", BUSY, 0);
        chk("a_to_score", SCORE, 2);

        // Game B: START clears GAME_OVER; timeout in round 1 keeps SCORE at 0.
        RAND = 1; START = 1'b1;
        tick();                       // n+1
        START = 1'b0;
        chk("b_go_clr", GAME_OVER, 0);
        chk("b_score_clr", SCORE, 0);
        repeat (8) tick();            // n+9
        chk("b_pre_to_go", GAME_OVER, 0);
        tick();                       // n+10
        chk("b_to_go", GAME_OVER, 1);
        chk("b_to_score", SCORE, 0);
        chk("b_to_busy", BUSY, 0);

        // Game C: full win with sequence 1,3,0.
        seq[0] = 1; seq[1] = 3; seq[2] = 0;
        RAND = seq[0]; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        play_show(1);
        answer(1);
        RAND = seq[1];
        tick(); tick();
        play_show(2);
        answer(2);
        RAND = seq[2];
        tick(); tick();
        play_show(3);
        answer(3);
        chk("c_win", WIN, 1);
        chk("c_go", GAME_OVER, 0);
        chk("c_busy", BUSY, 0);
        tick();
        chk("c_win_hold", WIN, 1);
        chk("c_score_hold", SCORE, 3);

        // Game D: restart clears WIN/SCORE; wrong entry in round 2.
        RAND = seq[0]; START = 1'b1;
        tick();
        START = 1'b0;
        chk("d_win_clr", WIN, 0);
        chk("d_score_clr", SCORE, 0);
        chk("d_busy", BUSY, 1);
        tick();
        play_show(1);
        answer(1);
        RAND = seq[1];
        tick(); tick();
        play_show(2);
        press(1);
        chk("d_mid_go", GAME_OVER, 0);
        press(2);
        chk("d_wrong_go", GAME_OVER, 1);
        chk("d_wrong_score", SCORE, 1);
        chk("d_wrong_busy", BUSY, 0);

        // Game E: reset in the middle of round-2 playback discards the score.
        seq[0] = 2;
        RAND = 2; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        play_show(1);
        answer(1);
        RAND = 1;
        tick(); tick();
        chk("e_show_ena", OUT_ENA, 1);
        RST = 1'b1;
        tick();
        chk("e_rst_ena", OUT_ENA, 0);
        chk("e_rst_busy", BUSY, 0);
        chk("e_rst_score", SCORE, 0);
        chk("e_rst_go", GAME_OVER, 0);
        chk("e_rst_win", WIN, 0);
        chk("e_rst_out", OUT, 0);
        RST = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/simon_engine.md
# simon_engine

Parametrised Simon game core: holds a growing random colour sequence, plays it back on N_CH lamps, checks player entries, and reports score, loss and win. It sits in the game top-level after the input synchroniser and RNG, and drives the lamp decoder. Over the first-generation controller it adds: configurable channel count and sequence depth, tick-based on/off/timeout timing, an input timeout, a win condition at full depth, and a score output.

## Interface
- N_CH, 4: lamp/button count; power of two, 2..16; CW = $clog2(N_CH)
- MAX_LEN, 32: sequence memory depth, 1..255; LW = $clog2(MAX_LEN+1)
- ON_TICKS, 4: TICK pulses a lamp stays lit during playback; ≥1
- OFF_TICKS, 2: TICK pulses of dark gap after each lamp and before each new round; ≥1
- TIMEOUT_TICKS, 50: TICK pulses allowed between player entries; ≥1

- CLK  in  1  single clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- TICK  in  1  one-CLK-wide timing strobe; all durations are counted in TICK pulses
- START  in  1  level, sampled each CLK; begins a game from IDLE
- IN  in  CW  encoded button index, qualified by IN_VALID
- IN_VALID  in  1  one-CLK pulse per button press
- RAND  in  CW  random channel, sampled in ADD
- OUT  out  CW  lamp index to light
- OUT_ENA  out  1  lamp enable
- BUSY  out  1  high in every state except IDLE
- SCORE  out  LW  rounds completed in the current/last game
- GAME_OVER  out  1  last game ended by a wrong entry or a timeout
- WIN  out  1  last game ended by completing MAX_LEN rounds

## Operation
- Storage: MAX_LEN × CW sequence memory, length counter LEN (LW bits), index IDX, tick timer.
- Reset: state IDLE; OUT=0, OUT_ENA=0, BUSY=0, SCORE=0, GAME_OVER=0, WIN=0, LEN=0, IDX=0, timer=0. Memory contents are don't-care.
- IDLE: START=1 → clear LEN, SCORE, GAME_OVER, WIN → ADD. GAME_OVER/WIN hold until then.
- ADD (one cycle): mem[LEN]←RAND, LEN←LEN+1, IDX←0, timer←0 → SHOW_ON.
- SHOW_ON: OUT=mem[IDX], OUT_ENA=1. On the ON_TICKS-th TICK → SHOW_OFF, timer←0.
- SHOW_OFF: OUT_ENA=0, OUT holds. On the OFF_TICKS-th TICK: if IDX==LEN-1, then IDX←0 and timer←0, → WAIT_IN; else IDX←IDX+1 → SHOW_ON.
- WAIT_IN: OUT_ENA=0. IN_VALID with IN==mem[IDX]: timer←0. If IDX==LEN-1, then SCORE←SCORE+1 and, if LEN==MAX_LEN, WIN←1 → IDLE, otherwise → PAUSE. If IDX<LEN-1, IDX←IDX+1.
- WAIT_IN, mismatch: IN_VALID with IN≠mem[IDX] → GAME_OVER←1 → IDLE.
- WAIT_IN, timeout: on the TIMEOUT_TICKS-th TICK with no IN_VALID → GAME_OVER←1 → IDLE.
- PAUSE: on the OFF_TICKS-th TICK → ADD.
- IN_VALID is ignored outside WAIT_IN. START is ignored outside IDLE.
- IN_VALID and the timeout TICK in the same cycle: IN_VALID wins.
- RST asserted mid-game forces the reset state immediately; no partial score is kept.
- The timer saturates and never wraps. SCORE never exceeds MAX_LEN.

## Timing
- All outputs are registered and change only on CLK edges, or asynchronously on RST.
- START high in cycle n → ADD in n+1 (RAND sampled at the end of n+1) → OUT_ENA=1 with OUT=RAND from cycle n+2.
- A state that waits K ticks leaves on the CLK edge that samples the K-th TICK=1 after entry. A TICK in the entry cycle itself does not count.
- Final correct entry in cycle m → SCORE updated and PAUSE/IDLE from cycle m+1. Wrong entry in m → GAME_OVER=1 and BUSY=0 from m+1.
- With TICK tied high: each played lamp lasts ON_TICKS+OFF_TICKS cycles.

## Test plan
Common setup: N_CH=4, MAX_LEN=3, ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=5, TICK tied high.
- Reset: RST pulse mid-SHOW_ON → next edge OUT_ENA=0, BUSY=0, SCORE=0, GAME_OVER=0, WIN=0.
- Round 1: RAND=2, START for 1 cycle → OUT_ENA=1 with OUT=2 in cycles n+2..n+3, low in n+4, then WAIT_IN; enter IN=2 → SCORE=1, and the second lamp (the old 2, then the new RAND) follows after a 1-cycle pause.
- Full win: RAND sequence 1,3,0 with every round answered correctly → SCORE=3, WIN=1, GAME_OVER=0, BUSY=0; START again clears WIN and SCORE.
- Wrong entry: sequence 1,3; in round 2 enter 1 then 2 → GAME_OVER=1 on the cycle after the 2, SCORE=1.
- Timeout: reach WAIT_IN and give no input for 5 cycles → GAME_OVER=1, SCORE=0. An entry on the 4th cycle resets the timer and avoids the timeout.
- Ignored inputs: IN_VALID pulses during SHOW_ON/SHOW_OFF and START pulses while BUSY → no change in IDX, SCORE or state sequence.
